// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline-control sequencer for the 5-stage RV32I core.
// Drives per-stage stall/flush enables and EX operand forwarding selects, and
// sequences load-use bubbles, branch flushes and data-memory wait states.
// Control outputs are combinational from registered state plus current inputs;
// state and the saturating event counters update on the rising clock edge.
module hazard_sequencer #(
  parameter int LU_CYCLES = 1,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_en,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_wr,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_wr,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int LU_W   = (LU_CYCLES > 1) ? $clog2(LU_CYCLES + 1) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [LU_W-1:0]   lu_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_hit;
  logic              br_flush;

  // Pick the youngest in-flight producer of a register; MEM beats WB, x0 never forwards.
  function automatic logic [1:0] fwd_select(input logic [4:0] rs,
                                            input logic [4:0] m_rd, input logic m_wr,
                                            input logic [4:0] w_rd, input logic w_wr);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_wr && (m_rd != 5'd0) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Forwarding selects apply in every state but are forced to the regfile during reset.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!rst) begin
      fwd_a_sel = fwd_select(ex_rs1, mem_rd, mem_reg_wr, wb_rd, wb_reg_wr);
      fwd_b_sel = fwd_select(ex_rs2, mem_rd, mem_reg_wr, wb_rd, wb_reg_wr);
    end
  end

  // A load in EX whose destination is read by the instruction in ID needs a bubble.
  always_comb begin
    lu_hit = ex_rd_en && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
  end

  // Same-cycle stall/flush decode: memory wait beats branch flush beats load-use bubble.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    br_flush  = 1'b0;
    if (rst) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      case (state)
        RUN, LU_STALL: begin
          if (dmem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
          end else if (br_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            br_flush = 1'b1;
          end else if ((state == LU_STALL) || lu_hit) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
          end
        end
        default: begin
          stall_if = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, bubble/wait counters, sticky timeout and saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      lu_cnt      <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (br_flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
      case (state)
        RUN: begin
          if (dmem_busy) begin
            wait_cnt <= WAIT_W'(1);
            state    <= MEM_WAIT;
          end else if (br_taken) begin
            state <= RUN;
          end else if (lu_hit && (LU_CYCLES > 1)) begin
            lu_cnt <= LU_W'(LU_CYCLES - 1);
            state  <= LU_STALL;
          end
        end
        LU_STALL: begin
          if (dmem_busy) begin
            lu_cnt   <= '0;
            wait_cnt <= WAIT_W'(1);
            state    <= MEM_WAIT;
          end else if (br_taken) begin
            lu_cnt <= '0;
            state  <= RUN;
          end else begin
            lu_cnt <= lu_cnt - 1'b1;
            if (lu_cnt == LU_W'(1)) begin
              state <= RUN;
            end
          end
        end
        MEM_WAIT: begin
          if (!dmem_busy) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: scoreboard bench for hazard_sequencer.
// Two instances share all inputs: dut_a (LU_CYCLES=2, TIMEOUT=3, CNT_W=16) and
// dut_b (LU_CYCLES=4, TIMEOUT=255, CNT_W=2). Stimulus pushes hand-computed
// expectations per cycle; a monitor pops and compares on the falling edge.
module tb_hazard_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_rd_en, mem_reg_wr, wb_reg_wr, br_taken, dmem_busy;

  logic a_stall_if, a_stall_id, a_stall_ex, a_stall_mem, a_flush_id, a_flush_ex, a_err;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic [15:0] a_stall_count, a_flush_count;

  logic b_stall_if, b_stall_id, b_stall_ex, b_stall_mem, b_flush_id, b_flush_ex, b_err;
  logic [1:0] b_fwd_a, b_fwd_b;
  logic [1:0] b_stall_count, b_flush_count;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [1:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    int         sc;
    int         fc;
    bit         b_chk;
    logic [3:0] b_st;
    logic [1:0] b_fl;
    int         b_sc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int passed = 0;

  // Free-running core clock.
  always #5 clk = ~clk;

  hazard_sequencer #(.LU_CYCLES(2), .TIMEOUT(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .br_taken(br_taken), .dmem_busy(dmem_busy),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .stall_ex(a_stall_ex), .stall_mem(a_stall_mem),
    .flush_id(a_flush_id), .flush_ex(a_flush_ex),
    .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b), .err_timeout(a_err),
    .stall_count(a_stall_count), .flush_count(a_flush_count)
  );

  hazard_sequencer #(.LU_CYCLES(4), .TIMEOUT(255), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .br_taken(br_taken), .dmem_busy(dmem_busy),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .stall_ex(b_stall_ex), .stall_mem(b_stall_mem),
    .flush_id(b_flush_id), .flush_ex(b_flush_ex),
    .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b), .err_timeout(b_err),
    .stall_count(b_stall_count), .flush_count(b_flush_count)
  );

  task automatic idleInputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_rd_en = 1'b0;
    mem_rd = 5'd0; mem_reg_wr = 1'b0; wb_rd = 5'd0; wb_reg_wr = 1'b0;
    br_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  // Load x3 in EX while the ID instruction reads x3 through rs2.
  task automatic loadUseInputs();
    idleInputs();
    ex_rd_en = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    id_rs2 = 5'd3; id_use_rs2 = 1'b1;
  endtask

  task automatic pushAndStep(input exp_t e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] st, input logic [1:0] fl,
                               input logic [1:0] fa, input logic [1:0] fb, input logic err,
                               input int sc, input int fc);
    exp_t e;
    e.name = name; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err;
    e.sc = sc; e.fc = fc; e.b_chk = 1'b0; e.b_st = 4'b0000; e.b_fl = 2'b00; e.b_sc = 0;
    pushAndStep(e);
  endtask

  task automatic applyStimulusB(input string name, input logic [3:0] st, input logic [1:0] fl,
                                input logic err, input int sc, input int fc,
                                input logic [3:0] b_st, input logic [1:0] b_fl, input int b_sc);
    exp_t e;
    e.name = name; e.st = st; e.fl = fl; e.fa = 2'b00; e.fb = 2'b00; e.err = err;
    e.sc = sc; e.fc = fc; e.b_chk = 1'b1; e.b_st = b_st; e.b_fl = b_fl; e.b_sc = b_sc;
    pushAndStep(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] got_st;
    logic [1:0] got_fl;
    got_st = {a_stall_if, a_stall_id, a_stall_ex, a_stall_mem};
    got_fl = {a_flush_id, a_flush_ex};
    checks++;
    if ((got_st === e.st) && (got_fl === e.fl) && (a_fwd_a === e.fa) && (a_fwd_b === e.fb) &&
        (a_err === e.err) && (a_stall_count === 16'(e.sc)) && (a_flush_count === 16'(e.fc))) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s (dut_a): got st=%b fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d, expected st=%b fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
               e.name, got_st, got_fl, a_fwd_a, a_fwd_b, a_err, a_stall_count, a_flush_count,
               e.st, e.fl, e.fa, e.fb, e.err, e.sc, e.fc);
    end
    if (e.b_chk) begin
      got_st = {b_stall_if, b_stall_id, b_stall_ex, b_stall_mem};
      got_fl = {b_flush_id, b_flush_ex};
      checks++;
      if ((got_st === e.b_st) && (got_fl === e.b_fl) && (b_stall_count === 2'(e.b_sc))) begin
        passed++;
      end else begin
        $display("[TB] FAIL %s (dut_b): got st=%b fl=%b sc=%0d, expected st=%b fl=%b sc=%0d",
                 e.name, got_st, got_fl, b_stall_count, e.b_st, e.b_fl, e.b_sc);
      end
    end
  endtask

  // Monitor: compare one queued expectation per cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idleInputs();
    mem_reg_wr = 1'b1; mem_rd = 5'd5; ex_rs1 = 5'd5; br_taken = 1'b1; dmem_busy = 1'b1;
    @(posedge clk);
    #1;
    applyStimulusB("reset_outputs", 4'b0000, 2'b11, 1'b0, 0, 0, 4'b0000, 2'b11, 0);

    // Forwarding
    rst = 1'b0;
    idleInputs();
    ex_rs1 = 5'd5; ex_rs2 = 5'd5; mem_rd = 5'd5; mem_reg_wr = 1'b1; wb_rd = 5'd5; wb_reg_wr = 1'b1;
    applyStimulus("fwd_mem_prio", 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 0, 0);
    mem_reg_wr = 1'b0;
    applyStimulus("fwd_wb", 4'b0000, 2'b00, 2'b10, 2'b10, 1'b0, 0, 0);
    mem_reg_wr = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    applyStimulus("fwd_x0", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0);
    ex_rs1 = 5'd5; ex_rs2 = 5'd7; mem_rd = 5'd5; wb_rd = 5'd7;
    applyStimulus("fwd_split_a_mem", 4'b0000, 2'b00, 2'b01, 2'b10, 1'b0, 0, 0);
    ex_rs1 = 5'd5; ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd5;
    applyStimulus("fwd_split_b_mem", 4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 0, 0);

    // Load-use bubble, LU_CYCLES=2
    loadUseInputs();
    applyStimulus("lu_stall_1", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0, 0, 0);
    applyStimulus("lu_stall_2", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0, 1, 0);
    idleInputs();
    applyStimulus("lu_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0);
    ex_rd_en = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    applyStimulus("lu_rd_zero", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0);
    idleInputs();
    ex_rd_en = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6; id_rs2 = 5'd6;
    applyStimulus("lu_no_use", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2, 0);

    // Branch flush priority over load-use
    loadUseInputs();
    br_taken = 1'b1;
    applyStimulus("br_over_lu", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 2, 0);
    idleInputs();
    applyStimulus("br_after", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 2, 1);
    loadUseInputs();
    applyStimulus("lu_before_br", 4'b1100, 2'b01, 2'b00, 2'b00, 1'b0, 2, 1);
    br_taken = 1'b1;
    applyStimulus("br_in_lu_stall", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 3, 1);
    idleInputs();
    applyStimulus("br_lu_after", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 3, 2);

    // Short memory wait, branch ignored while frozen
    dmem_busy = 1'b1;
    applyStimulus("busy_enter", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 3, 2);
    br_taken = 1'b1;
    applyStimulus("busy_br_ignored", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 4, 2);
    idleInputs();
    applyStimulus("busy_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5, 2);
    applyStimulus("busy_after", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b0, 5, 2);

    // Timeout with TIMEOUT=3 and busy for 5 cycles
    dmem_busy = 1'b1;
    applyStimulus("timeout_c1", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 5, 2);
    applyStimulus("timeout_c2", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 6, 2);
    applyStimulus("timeout_c3", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 7, 2);
    applyStimulus("timeout_c4", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 8, 2);
    applyStimulus("timeout_c5", 4'b1111, 2'b00, 2'b00, 2'b00, 1'b1, 9, 2);
    idleInputs();
    applyStimulus("timeout_release", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 10, 2);
    applyStimulus("timeout_sticky", 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 10, 2);
    rst = 1'b1;
    applyStimulus("timeout_rst", 4'b0000, 2'b11, 2'b00, 2'b00, 1'b1, 10, 2);
    rst = 1'b0;
    applyStimulusB("post_rst", 4'b0000, 2'b00, 1'b0, 0, 0, 4'b0000, 2'b00, 0);

    // Reset in the middle of a long load-use stall
    loadUseInputs();
    applyStimulusB("rst_lu_c1", 4'b1100, 2'b01, 1'b0, 0, 0, 4'b1100, 2'b01, 0);
    applyStimulusB("rst_lu_c2", 4'b1100, 2'b01, 1'b0, 1, 0, 4'b1100, 2'b01, 1);
    rst = 1'b1;
    applyStimulusB("rst_lu_rst", 4'b0000, 2'b11, 1'b0, 2, 0, 4'b0000, 2'b11, 2);
    rst = 1'b0;
    idleInputs();
    applyStimulusB("rst_lu_after", 4'b0000, 2'b00, 1'b0, 0, 0, 4'b0000, 2'b00, 0);

    // Counter saturation on the 2-bit instance
    loadUseInputs();
    applyStimulusB("sat_c1", 4'b1100, 2'b01, 1'b0, 0, 0, 4'b1100, 2'b01, 0);
    applyStimulusB("sat_c2", 4'b1100, 2'b01, 1'b0, 1, 0, 4'b1100, 2'b01, 1);
    applyStimulusB("sat_c3", 4'b1100, 2'b01, 1'b0, 2, 0, 4'b1100, 2'b01, 2);
    applyStimulusB("sat_c4", 4'b1100, 2'b01, 1'b0, 3, 0, 4'b1100, 2'b01, 3);
    applyStimulusB("sat_c5", 4'b1100, 2'b01, 1'b0, 4, 0, 4'b1100, 2'b01, 3);
    idleInputs();
    applyStimulusB("sat_c6", 4'b1100, 2'b01, 1'b0, 5, 0, 4'b1100, 2'b01, 3);
    rst = 1'b1;
    applyStimulusB("sat_rst", 4'b0000, 2'b11, 1'b0, 6, 0, 4'b0000, 2'b11, 3);
    rst = 1'b0;
    applyStimulusB("sat_cleared", 4'b0000, 2'b00, 1'b0, 0, 0, 4'b0000, 2'b00, 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
